wrr_arbiter_locking: RTL and testbench

- Weighted round-robin, burst-locking N:1 arbiter for decoupled_burst_intr streams.
- Grant is held from the first presented beat until the requestor's last beat is accepted. Bursts are never interleaved, even if the owner drops valid mid-burst.
- Each requestor may issue up to cfg_weight consecutive bursts per turn. A runtime mode selects fixed priority instead.
- An optional output skid register breaks the ready/valid timing path. Used in front of shared memory and NoC ports.

---
 rtl/wrr_arb_pkg.sv | 18 +
 rtl/decoupled_burst_intr.sv | 24 ++
 rtl/burst_skid_buffer.sv | 58 +++++
 rtl/wrr_arbiter_locking.sv | 158 +++++++++++++++
 tb/tb_wrr_arbiter_locking.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin locking arbiter.
// Index arithmetic wraps modulo the requestor count.
package wrr_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoupled_burst_intr.sv
// Valid/ready stream with a last-beat marker.
// Master drives payload, slave drives ready.
interface decoupled_burst_intr #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic          last;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output last,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    output ready
  );
endinterface

// File: rtl/burst_skid_buffer.sv
// Two-entry skid register: outputs come straight from flops and
// input ready depends only on local state, never on out_ready_i.
module burst_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i
);

  logic                  ov_q;
  logic [DATA_WIDTH-1:0] od_q;
  logic                  ol_q;
  logic                  sv_q;
  logic [DATA_WIDTH-1:0] sd_q;
  logic                  sl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
      sv_q <= 1'b0;
      sd_q <= '0;
      sl_q <= 1'b0;
    end else if (!sv_q) begin
      if (out_ready_i || !ov_q) begin
        ov_q <= in_valid_i;
        if (in_valid_i) begin
          od_q <= in_data_i;
          ol_q <= in_last_i;
        end
      end else if (in_valid_i) begin
        // output stalled: park the beat in the skid slot
        sv_q <= 1'b1;
        sd_q <= in_data_i;
        sl_q <= in_last_i;
      end
    end else if (out_ready_i) begin
      od_q <= sd_q;
      ol_q <= sl_q;
      sv_q <= 1'b0;
    end
  end

  assign in_ready_o  = !sv_q;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_last_o  = ol_q;

endmodule

// File: rtl/wrr_arbiter_locking.sv
// Weighted round-robin N:1 stream arbiter that locks onto a requestor
// from its first presented beat until its last beat is accepted.
module wrr_arbiter_locking
  import wrr_arb_pkg::*;
#(
  parameter int NUM_REQUESTORS = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int WEIGHT_WIDTH   = 4,
  parameter bit OUTPUT_REG     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  decoupled_burst_intr.slave  in_req [NUM_REQUESTORS],
  decoupled_burst_intr.master out_grant,
  input  logic [NUM_REQUESTORS*WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic cfg_prio_mode,
  output logic [$clog2(NUM_REQUESTORS)-1:0] grant_idx,
  output logic grant_active
);

  localparam int N  = NUM_REQUESTORS;
  localparam int IW = idx_w(N);
  localparam int WW = WEIGHT_WIDTH;

  logic [N-1:0]          v, l, rdy;
  logic [DATA_WIDTH-1:0] d [N];

  state_t          state_q;
  logic [IW-1:0]   owner_q, ptr_q;
  logic [WW-1:0]   credit_q;

  logic [IW-1:0]   cand, scan, sel, base_p, eob_p;
  logic [WW-1:0]   base_c, eob_c, w;
  logic            any, found, locked;
  logic            fwd_v, fwd_l, dr, acc, eob;
  logic [DATA_WIDTH-1:0] fwd_d;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign v[g] = in_req[g].valid;
    assign l[g] = in_req[g].last;
    assign d[g] = in_req[g].data;
    assign in_req[g].ready = rdy[g];
  end

  assign locked = (state_q == LOCKED);

  always_comb begin
    cand  = '0;
    found = 1'b0;
    scan  = ptr_q;
    any   = |v;
    for (int k = 0; k < N; k++) begin
      if (!found && v[scan]) begin
        cand  = scan;
        found = 1'b1;
      end
      scan = IW'(wrap_inc(32'(scan), N));
    end
    if (cfg_prio_mode) begin
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (v[k]) cand = IW'(k);
      end
    end
  end

  always_comb begin
    sel   = locked ? owner_q : cand;
    fwd_v = !rst && (locked ? v[sel] : any);
    fwd_d = d[sel];
    fwd_l = l[sel];
    rdy   = '0;
    if (!rst && (locked || any)) rdy[sel] = dr;
  end

  assign acc = fwd_v && dr;
  assign eob = acc && fwd_l;

  // a fresh grant to a new requestor restarts its quota before counting
  always_comb begin
    base_p = locked ? ptr_q : cand;
    base_c = (!locked && cand != ptr_q) ? '0 : credit_q;
    w = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == base_p) w = cfg_weight[k*WW +: WW];
    end
    if (w == '0) w = WW'(1);
    eob_p = base_p;
    eob_c = base_c;
    if (!cfg_prio_mode) begin
      if (({1'b0, base_c} + (WW+1)'(1)) >= {1'b0, w}) begin
        eob_p = IW'(wrap_inc(32'(base_p), N));
        eob_c = '0;
      end else begin
        eob_c = base_c + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            owner_q <= cand;
            if (eob) begin
              ptr_q    <= eob_p;
              credit_q <= eob_c;
            end else begin
              ptr_q    <= base_p;
              credit_q <= base_c;
              state_q  <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (eob) begin
            ptr_q    <= eob_p;
            credit_q <= eob_c;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_idx    = owner_q;
  assign grant_active = locked;

  if (OUTPUT_REG) begin : g_skid
    burst_skid_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (fwd_v),
      .in_data_i   (fwd_d),
      .in_last_i   (fwd_l),
      .in_ready_o  (dr),
      .out_valid_o (out_grant.valid),
      .out_data_o  (out_grant.data),
      .out_last_o  (out_grant.last),
      .out_ready_i (out_grant.ready)
    );
  end else begin : g_comb
    assign dr              = out_grant.ready;
    assign out_grant.valid = fwd_v;
    assign out_grant.data  = rst ? '0 : fwd_d;
    assign out_grant.last  = !rst && fwd_l;
  end

endmodule

// File: tb/tb_wrr_arbiter_locking.sv
// Bench for wrr_arbiter_locking: directed vectors, corner sequences
// and random traffic against a turn-based burst-order model.
module tb_wrr_arbiter_locking;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    bit         prio;
    int         pre;
    logic [3:0] vm;
    logic [3:0] er;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rv, rl, rrdy;
  logic [DW-1:0]   rd [N];
  logic            ordy, ov, ol;
  logic [DW-1:0]   od;
  logic [N*WW-1:0] wt;
  logic            prio;
  logic [1:0]      gidx;
  logic            gact;

  decoupled_burst_intr #(.DW(DW)) req_if [N] ();
  decoupled_burst_intr #(.DW(DW)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_req
    assign req_if[g].valid = rv[g];
    assign req_if[g].data  = rd[g];
    assign req_if[g].last  = rl[g];
    assign rrdy[g]         = req_if[g].ready;
  end

  assign out_if.ready = ordy;
  assign ov = out_if.valid;
  assign od = out_if.data;
  assign ol = out_if.last;

  wrr_arbiter_locking #(
    .NUM_REQUESTORS(N),
    .DATA_WIDTH    (DW),
    .WEIGHT_WIDTH  (WW),
    .OUTPUT_REG    (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_req       (req_if),
    .out_grant    (out_if),
    .cfg_weight   (wt),
    .cfg_prio_mode(prio),
    .grant_idx    (gidx),
    .grant_active (gact)
  );

  int    errors = 0;
  int    checks = 0;
  beat_t rq [N][$];
  beat_t outq [$];
  beat_t expq [$];
  bit    mid [N];
  int    gap [N];
  int    nb [N];
  bit    acc [N];
  bit    rnd_drop, ordy_rand;
  int    blen [N][100];

  function automatic logic [DW-1:0] mk(int r, int b, int k);
    return {8'(r), 12'(b), 12'(k)};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_burst(int r, int len);
    for (int k = 0; k < len; k++)
      rq[r].push_back('{mk(r, nb[r], k), k == len - 1});
    nb[r]++;
  endtask

  // Expected stream: turns visit requestors in index order, each
  // turn emitting max(weight,1) whole bursts from that requestor.
  task automatic build_exp(int target);
    int p, wv;
    int used [N];
    expq.delete();
    for (int i = 0; i < N; i++) used[i] = 0;
    p = 0;
    while (expq.size() < target) begin
      wv = int'(wt[p*WW +: WW]);
      if (wv == 0) wv = 1;
      for (int t = 0; t < wv; t++) begin
        for (int k = 0; k < blen[p][used[p]]; k++)
          expq.push_back('{mk(p, used[p], k), k == blen[p][used[p]] - 1});
        used[p]++;
      end
      p = (p + 1) % N;
    end
  endtask

  task automatic drive();
    bit ok;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        rd[i] = rq[i][0].d;
        rl[i] = rq[i][0].l;
        ok = 1'b1;
        if (mid[i] && gap[i] > 0) begin
          ok = 1'b0;
          gap[i]--;
        end else if (mid[i] && rnd_drop && $urandom_range(0, 9) < 3) begin
          ok = 1'b0;
        end
        rv[i] = ok;
      end else begin
        rv[i] = 1'b0;
        rl[i] = 1'b0;
      end
    end
    ordy = ordy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic step();
    beat_t b;
    #1;
    for (int i = 0; i < N; i++) acc[i] = rv[i] && rrdy[i];
    if (ov && ordy) outq.push_back('{od, ol});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        b = rq[i].pop_front();
        mid[i] = !b.l;
      end
    end
    drive();
    @(negedge clk);
  endtask

  task automatic run_until(int n, int budget);
    int c = 0;
    while (outq.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("beats_out", (outq.size() >= n) ? n : outq.size(), n);
  endtask

  task automatic check_out(int n, string nm);
    for (int k = 0; k < n && k < outq.size(); k++) begin
      chk({nm, "_data"}, outq[k].d, expq[k].d);
      chk({nm, "_last"}, outq[k].l, expq[k].l);
    end
  endtask

  task automatic finish_reset();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      mid[i] = 1'b0;
      gap[i] = 0;
      nb[i]  = 0;
    end
    outq.delete();
    rnd_drop  = 1'b0;
    ordy_rand = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_last", ol, 0);
    chk("rst_ready", 32'(rrdy), 0);
    chk("rst_gidx", 32'(gidx), 0);
    chk("rst_active", gact, 0);
    finish_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [9];
    tv[0] = '{1'b0, -1, 4'b0000, 4'b0000};
    tv[1] = '{1'b0, -1, 4'b1010, 4'b0010};
    tv[2] = '{1'b0,  0, 4'b1001, 4'b1000};
    tv[3] = '{1'b1,  0, 4'b1001, 4'b0001};
    tv[4] = '{1'b0,  3, 4'b1001, 4'b0001};
    tv[5] = '{1'b0,  2, 4'b0011, 4'b0001};
    tv[6] = '{1'b0,  2, 4'b1010, 4'b1000};
    tv[7] = '{1'b1,  2, 4'b1110, 4'b0010};
    tv[8] = '{1'b0,  1, 4'b0011, 4'b0001};

    rv = '1;
    rl = '0;
    ordy = 1'b1;
    prio = 1'b0;
    wt = {4{4'd1}};
    for (int i = 0; i < N; i++) rd[i] = '0;
    do_reset();

    // IDLE selection from a known pointer position
    foreach (tv[j]) begin
      prio = tv[j].prio;
      do_reset();
      if (tv[j].pre >= 0) begin
        push_burst(tv[j].pre, 1);
        drive();
        step();
      end
      for (int i = 0; i < N; i++)
        if (tv[j].vm[i]) push_burst(i, 1);
      drive();
      #1;
      chk("tbl_ready", 32'(rrdy), 32'(tv[j].er));
    end

    // equal weights, 3-beat bursts
    prio = 1'b0;
    wt = {4{4'd1}};
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 100; b++) blen[i][b] = 3;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) push_burst(i, 3);
    build_exp(15);
    drive();
    run_until(15, 200);
    check_out(15, "rr3");

    // weight 2 on requestor 0, single-beat bursts, full throughput
    wt = {4'd1, 4'd1, 4'd1, 4'd2};
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 100; b++) blen[i][b] = 1;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 10; b++) push_burst(i, 1);
    build_exp(12);
    drive();
    #1;
    chk("lat_first_valid", ov, 0);
    for (int s = 0; s < 12; s++) begin
      step();
      chk("thru_valid", ov, 1);
    end
    run_until(12, 50);
    check_out(12, "wrr");

    // owner stalls mid-burst while another requestor waits
    wt = {4{4'd1}};
    do_reset();
    push_burst(1, 4);
    push_burst(2, 2);
    gap[1] = 5;
    drive();
    #1;
    chk("drop_pre_valid", ov, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("drop_rdy2", rrdy[2], 0);
      chk("drop_active", gact, 1);
      chk("drop_gidx", 32'(gidx), 1);
      if (k > 0) chk("drop_valid", ov, 0);
    end
    expq.delete();
    for (int k = 0; k < 4; k++) expq.push_back('{mk(1, 0, k), k == 3});
    for (int k = 0; k < 2; k++) expq.push_back('{mk(2, 0, k), k == 1});
    run_until(6, 60);
    check_out(6, "drop");

    // fixed priority: lock survives, then lowest index dominates
    prio = 1'b1;
    do_reset();
    push_burst(3, 3);
    drive();
    step();
    push_burst(0, 1);
    push_burst(0, 1);
    push_burst(1, 1);
    drive();
    expq.delete();
    for (int k = 0; k < 3; k++) expq.push_back('{mk(3, 0, k), k == 2});
    expq.push_back('{mk(0, 0, 0), 1'b1});
    expq.push_back('{mk(0, 1, 0), 1'b1});
    expq.push_back('{mk(1, 0, 0), 1'b1});
    run_until(6, 60);
    check_out(6, "prio");

    // asynchronous reset in the middle of a burst
    prio = 1'b0;
    do_reset();
    push_burst(2, 4);
    drive();
    step();
    step();
    chk("arst_pre_active", gact, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", ov, 0);
    chk("arst_data", od, 0);
    chk("arst_active", gact, 0);
    chk("arst_ready", 32'(rrdy), 0);
    chk("arst_gidx", 32'(gidx), 0);
    finish_reset();
    push_burst(1, 1);
    push_burst(3, 1);
    drive();
    expq.delete();
    expq.push_back('{mk(1, 0, 0), 1'b1});
    expq.push_back('{mk(3, 0, 0), 1'b1});
    run_until(2, 20);
    check_out(2, "arst");

    // random weights, lengths, owner stalls and downstream ready
    for (int it = 0; it < 2; it++) begin
      prio = 1'b0;
      for (int i = 0; i < N; i++) wt[i*WW +: WW] = 4'($urandom_range(0, 3));
      do_reset();
      rnd_drop  = 1'b1;
      ordy_rand = 1'b1;
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 100; b++) blen[i][b] = $urandom_range(1, 4);
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 80; b++) push_burst(i, blen[i][b]);
      build_exp(120);
      drive();
      run_until(120, 3000);
      check_out(120, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
